// File: rtl/mux2_rr_arbiter.sv
// rtl/mux2_rr_arbiter.sv - two-requester round-robin arbiter driving a shared MUX2 datapath

// One bit of the shared datapath: y = s ? b : a.
module mux2_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic s_i,
  output logic y_o
);

  // Plain 2:1 select, kept as its own cell so each data bit maps to one MUX2.
  assign y_o = s_i ? b_i : a_i;

endmodule

// Round-robin owner of a W-bit channel shared by requesters A and B.
// Grants and select are registered. A requester may hold the channel
// indefinitely while the other side is quiet. Once the other side asks,
// the owner is limited to MAX_HOLD beats.
module mux2_rr_arbiter #(
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         REQ_A,
  input  logic         REQ_B,
  input  logic [W-1:0] DATA_A,
  input  logic [W-1:0] DATA_B,
  output logic         GNT_A,
  output logic         GNT_B,
  output logic         SEL,
  output logic [W-1:0] Y_DATA,
  output logic         Y_VALID
);

  localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_beat;
  logic            ptr_b_q, ptr_b_d;   // 1: next contention from IDLE goes to B
  logic            sel_q, sel_d;
  logic            gnt_a_q, gnt_a_d;
  logic            gnt_b_q, gnt_b_d;

  // Beat count including the beat being taken in the current cycle, saturating.
  // Comparing this value, rather than the registered count, makes a forced
  // rotation happen after exactly MAX_HOLD owned cycles.
  always_comb begin
    cnt_beat = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
  end

  // Next-state arbitration: IDLE picks by pointer; an owner leaves on release or beat limit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_b_d = ptr_b_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (REQ_A && (!REQ_B || !ptr_b_q)) begin
          state_d = OWN_A;
          sel_d   = 1'b0;
        end else if (REQ_B) begin
          state_d = OWN_B;
          sel_d   = 1'b1;
        end
      end
      OWN_A: begin
        if (!REQ_A) begin
          ptr_b_d = 1'b1;
          cnt_d   = '0;
          if (REQ_B) begin
            state_d = OWN_B;
            sel_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if ((cnt_beat == CNT_MAX) && REQ_B) begin
          ptr_b_d = 1'b1;
          cnt_d   = '0;
          state_d = OWN_B;
          sel_d   = 1'b1;
        end else begin
          cnt_d = cnt_beat;
        end
      end
      OWN_B: begin
        if (!REQ_B) begin
          ptr_b_d = 1'b0;
          cnt_d   = '0;
          if (REQ_A) begin
            state_d = OWN_A;
            sel_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if ((cnt_beat == CNT_MAX) && REQ_A) begin
          ptr_b_d = 1'b0;
          cnt_d   = '0;
          state_d = OWN_A;
          sel_d   = 1'b0;
        end else begin
          cnt_d = cnt_beat;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Grants follow the next state so they are registered alongside it.
  always_comb begin
    gnt_a_d = (state_d == OWN_A);
    gnt_b_d = (state_d == OWN_B);
  end

  // State, counter, pointer and registered outputs; reset wins over any request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_b_q <= 1'b0;
      sel_q   <= 1'b0;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_b_q <= ptr_b_d;
      sel_q   <= sel_d;
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
    end
  end

  // Shared datapath: one MUX2 per bit steered by the registered select.
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_mux
      mux2_cell u_mux (
        .a_i (DATA_A[gi]),
        .b_i (DATA_B[gi]),
        .s_i (sel_q),
        .y_o (Y_DATA[gi])
      );
    end
  endgenerate

  assign GNT_A   = gnt_a_q;
  assign GNT_B   = gnt_b_q;
  assign SEL     = sel_q;
  assign Y_VALID = (gnt_a_q & REQ_A) | (gnt_b_q & REQ_B);

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb/tb_mux2_rr_arbiter.sv - directed self-checking bench for mux2_rr_arbiter

module tb_mux2_rr_arbiter;

  logic       CLK;
  logic       RST;
  logic       REQ_A;
  logic       REQ_B;
  logic [7:0] DATA_A;
  logic [7:0] DATA_B;
  logic       GNT_A;
  logic       GNT_B;
  logic       SEL;
  logic [7:0] Y_DATA;
  logic       Y_VALID;

  int checks;
  int errors;

  mux2_rr_arbiter #(.W(8), .MAX_HOLD(4)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .REQ_A   (REQ_A),
    .REQ_B   (REQ_B),
    .DATA_A  (DATA_A),
    .DATA_B  (DATA_B),
    .GNT_A   (GNT_A),
    .GNT_B   (GNT_B),
    .SEL     (SEL),
    .Y_DATA  (Y_DATA),
    .Y_VALID (Y_VALID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then park on the falling edge for sampling/driving.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    REQ_A = 1'b0;
    REQ_B = 1'b0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  logic [7:0] va [6];
  logic [7:0] vb [6];

  initial begin
    checks = 0;
    errors = 0;
    DATA_A = 8'h00;
    DATA_B = 8'h00;

    // Reset values
    do_reset();
    chk("rst_gnt_a", GNT_A, 0);
    chk("rst_gnt_b", GNT_B, 0);
    chk("rst_sel", SEL, 0);
    chk("rst_valid", Y_VALID, 0);

    // Single A request, then reset mid-burst
    REQ_A = 1'b1;
    DATA_A = 8'h3C;
    DATA_B = 8'hC3;
    tick();
    chk("a_gnt_a", GNT_A, 1);
    chk("a_gnt_b", GNT_B, 0);
    chk("a_sel", SEL, 0);
    chk("a_ydata", Y_DATA, 8'h3C);
    chk("a_valid", Y_VALID, 1);
    RST = 1'b1;
    tick();
    chk("mid_rst_gnt_a", GNT_A, 0);
    chk("mid_rst_gnt_b", GNT_B, 0);
    chk("mid_rst_sel", SEL, 0);
    chk("mid_rst_valid", Y_VALID, 0);
    RST = 1'b0;
    REQ_A = 1'b0;
    tick();
    chk("post_rst_idle", GNT_A, 0);

    // Contention from IDLE: A first; A releases after 2 beats, B follows with no bubble
    do_reset();
    REQ_A = 1'b1;
    REQ_B = 1'b1;
    tick();
    chk("cont_first_a", GNT_A, 1);
    tick();
    chk("cont_a_beat2", GNT_A, 1);
    REQ_A = 1'b0;
    tick();
    chk("handoff_gnt_b", GNT_B, 1);
    chk("handoff_gnt_a", GNT_A, 0);
    chk("handoff_sel", SEL, 1);
    REQ_B = 1'b0;
    tick();
    chk("b_rel_idle", {GNT_A, GNT_B}, 2'b00);
    REQ_A = 1'b1;
    REQ_B = 1'b1;
    tick();
    chk("next_cont_a", GNT_A, 1);
    REQ_A = 1'b0;
    REQ_B = 1'b0;
    tick();

    // Both held: 4-beat bursts A,B,A,B
    do_reset();
    REQ_A = 1'b1;
    REQ_B = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("rot_gnt_a", GNT_A, ((k / 4) % 2 == 0) ? 1 : 0);
      chk("rot_gnt_b", GNT_B, ((k / 4) % 2 == 1) ? 1 : 0);
      chk("rot_excl", GNT_A & GNT_B, 0);
    end
    REQ_A = 1'b0;
    REQ_B = 1'b0;
    tick();

    // Only B for 10 cycles: no rotation
    do_reset();
    REQ_B = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("solo_b", GNT_B, 1);
    end

    // B ends with nobody requesting: IDLE, SEL held, Y_DATA follows DATA_B
    REQ_B = 1'b0;
    DATA_A = 8'h5A;
    DATA_B = 8'hA5;
    tick();
    chk("idle_gnt", {GNT_A, GNT_B}, 2'b00);
    chk("idle_sel", SEL, 1);
    chk("idle_valid", Y_VALID, 0);
    chk("idle_ydata", Y_DATA, 8'hA5);
    DATA_B = 8'h11;
    #1;
    chk("idle_ydata_track", Y_DATA, 8'h11);

    // Saturated counter: A joining late rotates at the very next edge
    REQ_B = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    chk("sat_b_hold", GNT_B, 1);
    REQ_A = 1'b1;
    tick();
    chk("sat_rot_gnt_a", GNT_A, 1);
    chk("sat_rot_sel", SEL, 0);

    // OWN_B burst with toggling data: only DATA_B reaches Y_DATA
    REQ_A = 1'b0;
    tick();
    chk("tog_gnt_b", GNT_B, 1);
    va[0] = 8'h01; vb[0] = 8'hF0;
    va[1] = 8'hFE; vb[1] = 8'h0F;
    va[2] = 8'h55; vb[2] = 8'hAA;
    va[3] = 8'hAA; vb[3] = 8'h55;
    va[4] = 8'h00; vb[4] = 8'hFF;
    va[5] = 8'hFF; vb[5] = 8'h00;
    for (int k = 0; k < 6; k++) begin
      DATA_A = va[k];
      DATA_B = vb[k];
      #1;
      chk("tog_ydata", Y_DATA, vb[k]);
      chk("tog_valid", Y_VALID, 1);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
